// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types and constants for the Sobel column reader
// Optional feature macro: SOBEL_EDGE_REPLICATE_EN (edge replication instead of zero padding)
package sobel_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    EDGE_ZERO_PAD  = 1'b0,
    EDGE_REPLICATE = 1'b1
  } edge_mode_e;

`ifdef SOBEL_EDGE_REPLICATE_EN
  localparam edge_mode_e EDGE_MODE = EDGE_REPLICATE;
`else
  localparam edge_mode_e EDGE_MODE = EDGE_ZERO_PAD;
`endif

endpackage

// File: rtl/sobel_addr_gen.sv
// rtl/sobel_addr_gen.sv - column-major scan counters, centre accumulator and edge clamping
module sobel_addr_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] addr_l_o,
  output logic [ADDR_W-1:0] addr_c_o,
  output logic [ADDR_W-1:0] addr_r_o,
  output logic              first_o,
  output logic              last_o,
  output logic              edge_l_o,
  output logic              edge_r_o,
  output logic              frame_end_o
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0]     X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] acc_q, acc_d;

  // Next scan position: walk down the column, then restart at the top of the next one.
  // The centre address follows by adding one row stride, or jumping to x+1 on column wrap.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    acc_d = acc_q;
    if (clear_i) begin
      x_d   = '0;
      y_d   = '0;
      acc_d = '0;
    end else if (advance_i) begin
      if (y_q == Y_LAST) begin
        y_d = '0;
        if (x_q == X_LAST) begin
          x_d   = '0;
          acc_d = '0;
        end else begin
          x_d   = x_q + XW'(1);
          acc_d = ADDR_W'(x_q) + ADDR_W'(1);
        end
      end else begin
        y_d   = y_q + YW'(1);
        acc_d = acc_q + ROW_STEP;
      end
    end
  end

  // Scan position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      acc_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      acc_q <= acc_d;
    end
  end

  // Neighbour addresses never leave the frame: at the side edges they fall back to the centre.
  always_comb begin
    edge_l_o    = (x_q == '0);
    edge_r_o    = (x_q == X_LAST);
    first_o     = (y_q == '0);
    last_o      = (y_q == Y_LAST);
    frame_end_o = edge_r_o && last_o;
    addr_c_o    = acc_q;
    addr_l_o    = edge_l_o ? acc_q : acc_q - ADDR_W'(1);
    addr_r_o    = edge_r_o ? acc_q : acc_q + ADDR_W'(1);
  end

endmodule

// File: rtl/sobel_column_reader.sv
// rtl/sobel_column_reader.sv - frame reader emitting left/centre/right pixel triplets column by column
// Edge behaviour selected by SOBEL_EDGE_REPLICATE_EN (see sobel_pkg); default is zero padding.
module sobel_column_reader
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr_l,
  output logic [ADDR_W-1:0] mem_addr_c,
  output logic [ADDR_W-1:0] mem_addr_r,
  input  logic [PIX_W-1:0]  mem_rdata_l,
  input  logic [PIX_W-1:0]  mem_rdata_c,
  input  logic [PIX_W-1:0]  mem_rdata_r,
  output logic [PIX_W-1:0]  left_out,
  output logic [PIX_W-1:0]  current_out,
  output logic [PIX_W-1:0]  right_out,
  output logic              out_valid,
  output logic              col_first,
  output logic              col_last
);

  localparam bit PAD_ZERO = (EDGE_MODE == EDGE_ZERO_PAD);

  state_e state_q, state_d;
  logic   drain_q, drain_d;
  logic   accept, issue;

  logic [ADDR_W-1:0] gen_l, gen_c, gen_r;
  logic gen_first, gen_last, gen_edge_l, gen_edge_r, gen_frame_end;

  // Stage 1: flags travelling alongside the synchronous RAM read.
  logic v1_q, first1_q, last1_q, el1_q, er1_q;

  // Stage 2: registered outputs.
  logic [PIX_W-1:0] left_q, current_q, right_q;
  logic             out_valid_q, col_first_q, col_last_q;

  sobel_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (accept),
    .advance_i  (issue),
    .addr_l_o   (gen_l),
    .addr_c_o   (gen_c),
    .addr_r_o   (gen_r),
    .first_o    (gen_first),
    .last_o     (gen_last),
    .edge_l_o   (gen_edge_l),
    .edge_r_o   (gen_edge_r),
    .frame_end_o(gen_frame_end)
  );

  // FSM next state and per-state outputs; DRAIN lasts two cycles to flush the read pipeline.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    accept  = 1'b0;
    issue   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        busy  = 1'b1;
        issue = 1'b1;
        if (gen_frame_end) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drain_q) begin
          drain_d = 1'b0;
          state_d = ST_DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Addresses are driven only while reading so they rest at zero otherwise.
  always_comb begin
    mem_addr_l = issue ? gen_l : '0;
    mem_addr_c = issue ? gen_c : '0;
    mem_addr_r = issue ? gen_r : '0;
  end

  // Stage 1: carry beat flags in step with the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      el1_q    <= 1'b0;
      er1_q    <= 1'b0;
    end else begin
      v1_q     <= issue;
      first1_q <= issue && gen_first;
      last1_q  <= issue && gen_last;
      el1_q    <= issue && gen_edge_l;
      er1_q    <= issue && gen_edge_r;
    end
  end

  // Stage 2: output register; zero padding masks the out-of-frame neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      col_first_q <= 1'b0;
      col_last_q  <= 1'b0;
      left_q      <= '0;
      current_q   <= '0;
      right_q     <= '0;
    end else begin
      out_valid_q <= v1_q;
      col_first_q <= first1_q;
      col_last_q  <= last1_q;
      current_q   <= v1_q ? mem_rdata_c : '0;
      left_q      <= (v1_q && !(PAD_ZERO && el1_q)) ? mem_rdata_l : '0;
      right_q     <= (v1_q && !(PAD_ZERO && er1_q)) ? mem_rdata_r : '0;
    end
  end

  assign out_valid   = out_valid_q;
  assign col_first   = col_first_q;
  assign col_last    = col_last_q;
  assign left_out    = left_q;
  assign current_out = current_q;
  assign right_out   = right_q;

endmodule
